pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_pkg.sv | 35 +++
 rtl/pc_redirect_ctrl_branch_stats.sv | 62 ++++++
 rtl/pc_redirect_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// -----------------------------------------------------------------------------
// pc_redirect_pkg
//
// Purpose : Shared definitions for the fetch-PC redirect controller.
//           Holds the redirect FSM state encoding, the default reset vector,
//           and small helpers used by the top and the branch statistics
//           sub-module.
//
// Contents:
//   state_e            - redirect FSM states (RUN, BUBBLE)
//   RESET_VEC_DEFAULT  - default PC loaded on reset
//   PC_STEP            - sequential fetch increment (one 32-bit instruction)
//   CNT_MAX            - saturation value of the 32-bit statistics counters
//   sat_inc()          - saturating increment used by the counters
// -----------------------------------------------------------------------------
package pc_redirect_pkg;

  // RUN    : fetch stream is valid unless stalled.
  // BUBBLE : the instruction memory is still returning the word fetched at
  //          the old PC; the fetch at the redirect target is not yet valid.
  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] CNT_MAX           = 32'hFFFF_FFFF;

  // Increment by one unless already at the top of the range.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == CNT_MAX) ? CNT_MAX : value + 32'd1;
  endfunction

endpackage : pc_redirect_pkg

// File: rtl/pc_redirect_ctrl_branch_stats.sv
// -----------------------------------------------------------------------------
// branch_stats
//
// Purpose : Profiling counters for conditional branches seen in EX.
//           Only instantiated when the build defines BRANCH_STATS_EN.
//           A branch is counted once per non-stalled cycle in which it is
//           presented (a stalled cycle re-presents the same instruction, so
//           counting it would double-count). Both counters saturate.
//
// Ports   :
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset, clears both counters
//   br_valid_i       in   EX-stage instruction is a conditional branch
//   br_taken_i       in   branch condition result (ignored when not valid)
//   stall_i          in   pipeline hold; suppresses counting
//   br_total_o[31:0] out  number of branches executed
//   br_taken_cnt_o   out  number of branches taken
// -----------------------------------------------------------------------------
module branch_stats
  import pc_redirect_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid_i,
  input  logic        br_taken_i,
  input  logic        stall_i,
  output logic [31:0] br_total_o,
  output logic [31:0] br_taken_cnt_o
);

  logic [31:0] total_q, total_d;
  logic [31:0] taken_q, taken_d;
  logic        count_en;

  // br_taken is meaningless without br_valid, so it is gated here.
  assign count_en = br_valid_i & ~stall_i;

  always_comb begin
    total_d = total_q;
    taken_d = taken_q;
    if (count_en) begin
      total_d = sat_inc(total_q);
      if (br_taken_i) begin
        taken_d = sat_inc(taken_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
      taken_q <= '0;
    end else begin
      total_q <= total_d;
      taken_q <= taken_d;
    end
  end

  assign br_total_o     = total_q;
  assign br_taken_cnt_o = taken_q;

endmodule : branch_stats

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Purpose : Owns the fetch PC of a 5-stage in-order pipeline. Each cycle it
//           picks the next PC from (in priority order) a CSR trap/mret
//           redirect, an EX-stage taken branch or jump, a load-use stall hold,
//           or sequential fetch. A redirect squashes the younger IF/ID and
//           ID/EX contents and inserts one invalid fetch cycle to cover the
//           synchronous instruction-memory latency.
//
//           A taken branch/jump whose target has bit 1 set cannot be fetched;
//           it raises misalign_o instead of redirecting, and the PC continues
//           as if no control transfer were requested.
//
// Build option:
//   BRANCH_STATS_EN  - when defined, adds br_total_o / br_taken_cnt_o and the
//                      branch_stats counter sub-module. Undefined by default.
//
// Parameters:
//   RESET_VEC        - PC value loaded on reset
//
// Ports   :
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   br_valid         in   EX instruction is a conditional branch
//   br_taken         in   branch condition result for EX instruction
//   jump             in   EX instruction is jal/jalr
//   target[31:0]     in   branch/jump target from the ALU
//   csr_redirect     in   trap or mret redirect request
//   csr_target[31:0] in   mtvec/mepc target
//   stall            in   load-use hazard hold
//   pc_o[31:0]       out  fetch PC
//   if_valid_o       out  instruction fetched at pc_o is valid
//   flush_o          out  squash IF/ID and ID/EX at the next edge
//   misalign_o       out  taken target has bit 1 set (combinational)
//   br_total_o       out  (BRANCH_STATS_EN) branches executed
//   br_taken_cnt_o   out  (BRANCH_STATS_EN) branches taken
// -----------------------------------------------------------------------------
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        csr_redirect,
  input  logic [31:0] csr_target,
  input  logic        stall,
  output logic [31:0] pc_o,
  output logic        if_valid_o,
  output logic        flush_o,
`ifdef BRANCH_STATS_EN
  output logic        misalign_o,
  output logic [31:0] br_total_o,
  output logic [31:0] br_taken_cnt_o
`else
  output logic        misalign_o
`endif
);

  // ---------------------------------------------------------------------------
  // Redirect decode
  // ---------------------------------------------------------------------------
  logic        xfer_req;     // EX asks for a control transfer
  logic        xfer_ok;      // ... and its target is fetchable
  logic        redirect;
  logic [31:0] csr_pc;
  logic [31:0] xfer_pc;

  assign xfer_req = (br_valid & br_taken) | jump;
  assign xfer_ok  = xfer_req & ~target[1];
  assign redirect = csr_redirect | xfer_ok;

  // The CSR unit hands over word-aligned targets by construction; the ALU
  // target may carry jalr's bit 0, which is architecturally cleared.
  assign csr_pc  = {csr_target[31:2], 2'b00};
  assign xfer_pc = {target[31:1], 1'b0};

  // Low target bits that the alignment rules discard.
  logic unused_low_bits;
  assign unused_low_bits = ^{target[0], csr_target[1:0]};

  // A CSR redirect wins over the EX transfer, so a misaligned EX target is
  // irrelevant in that cycle and must not be reported.
  assign misalign_o = xfer_req & target[1] & ~csr_redirect;
  assign flush_o    = redirect;

  // ---------------------------------------------------------------------------
  // PC register
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;

  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_d = pc_q + PC_STEP;  // wraps modulo 2^32
    if (csr_redirect) begin
      pc_d = csr_pc;
    end else if (xfer_ok) begin
      pc_d = xfer_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

  // ---------------------------------------------------------------------------
  // Redirect FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Both states leave on the same condition: a redirect always opens (or
  // extends) a bubble, and a quiet cycle always returns to RUN. A back-to-back
  // redirect from BUBBLE keeps the fetch invalid for the new target too.
  always_comb begin
    state_d    = state_q;
    if_valid_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if_valid_o = ~stall;
        state_d    = redirect ? BUBBLE : RUN;
      end
      BUBBLE: begin
        if_valid_o = 1'b0;
        state_d    = redirect ? BUBBLE : RUN;
      end
      default: begin
        if_valid_o = 1'b0;
        state_d    = RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional branch statistics
  // ---------------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
  branch_stats u_branch_stats (
    .clk            (clk),
    .rst            (rst),
    .br_valid_i     (br_valid),
    .br_taken_i     (br_taken),
    .stall_i        (stall),
    .br_total_o     (br_total_o),
    .br_taken_cnt_o (br_taken_cnt_o)
  );
`endif

endmodule : pc_redirect_ctrl

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed vectors with hand-computed expectations. The stimulus process
// drives one cycle of inputs just after the rising edge and pushes the
// expected outputs for that cycle into a queue; the monitor samples the DUT
// on the falling edge and compares against the head of the queue.
// Define BRANCH_STATS_EN to also exercise the branch counters.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;
  import pc_redirect_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, br_taken, jump, csr_redirect, stall;
  logic [31:0] target, csr_target;
  logic [31:0] pc_o;
  logic        if_valid_o, flush_o, misalign_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_o, br_taken_cnt_o;
`endif

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_VEC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .jump           (jump),
    .target         (target),
    .csr_redirect   (csr_redirect),
    .csr_target     (csr_target),
    .stall          (stall),
    .pc_o           (pc_o),
    .if_valid_o     (if_valid_o),
    .flush_o        (flush_o),
`ifdef BRANCH_STATS_EN
    .misalign_o     (misalign_o),
    .br_total_o     (br_total_o),
    .br_taken_cnt_o (br_taken_cnt_o)
`else
    .misalign_o     (misalign_o)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        misalign;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus its expected outputs.
  task automatic cyc(input string name, input logic r,
                     input logic brv, input logic brt, input logic jmp, input logic [31:0] tgt,
                     input logic csr, input logic [31:0] csrt, input logic stl,
                     input logic [31:0] e_pc, input logic e_v, input logic e_f, input logic e_m);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; br_valid = brv; br_taken = brt; jump = jmp; target = tgt;
    csr_redirect = csr; csr_target = csrt; stall = stl;
    e.name = name; e.pc = e_pc; e.valid = e_v; e.flush = e_f; e.misalign = e_m;
    q.push_back(e);
  endtask

  // Monitor: compare every cycle for which an expectation was queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".pc"},       pc_o,              e.pc);
        check({e.name, ".if_valid"}, {31'd0, if_valid_o}, {31'd0, e.valid});
        check({e.name, ".flush"},    {31'd0, flush_o},    {31'd0, e.flush});
        check({e.name, ".misalign"}, {31'd0, misalign_o}, {31'd0, e.misalign});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

`ifdef BRANCH_STATS_EN
  task automatic br_cyc(input logic brv, input logic brt, input logic stl);
    @(posedge clk);
    #1;
    br_valid = brv; br_taken = brt; stall = stl; jump = 1'b0;
    target = 32'h0000_0042;  // misaligned: counted but no redirect
    csr_redirect = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_taken = 1'b0; jump = 1'b0; target = '0;
    csr_redirect = 1'b0; csr_target = '0; stall = 1'b0;

    //   name          rst brv brt jmp target        csr csr_target    stl  pc            v  f  m
    cyc("in_reset",    1,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0000, 1, 0, 0);
    cyc("free0",       0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0000, 1, 0, 0);
    cyc("free1",       0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0004, 1, 0, 0);
    cyc("free2",       0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0008, 1, 0, 0);
    cyc("free3",       0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_000C, 1, 0, 0);
    cyc("br_taken",    0,  1,  1,  0,  32'h40,       0,  32'h0,        0,   32'h0000_0010, 1, 1, 0);
    cyc("br_bubble",   0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0040, 0, 0, 0);
    cyc("br_resume",   0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0044, 1, 0, 0);
    cyc("br_not_tkn",  0,  1,  0,  0,  32'h80,       0,  32'h0,        0,   32'h0000_0048, 1, 0, 0);
    cyc("tkn_no_vld",  0,  0,  1,  0,  32'h300,      0,  32'h0,        0,   32'h0000_004C, 1, 0, 0);
    cyc("jmp_0x20",    0,  0,  0,  1,  32'h20,       0,  32'h0,        0,   32'h0000_0050, 1, 1, 0);
    cyc("stall0",      0,  0,  0,  0,  32'h0,        0,  32'h0,        1,   32'h0000_0020, 0, 0, 0);
    cyc("stall1",      0,  0,  0,  0,  32'h0,        0,  32'h0,        1,   32'h0000_0020, 0, 0, 0);
    cyc("stall_jmp",   0,  0,  0,  1,  32'h80,       0,  32'h0,        1,   32'h0000_0020, 0, 1, 0);
    cyc("jmp_bubble",  0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0080, 0, 0, 0);
    cyc("jmp_resume",  0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0084, 1, 0, 0);
    cyc("csr_vs_jmp",  0,  0,  0,  1,  32'h200,      1,  32'h100,      0,   32'h0000_0088, 1, 1, 0);
    cyc("csr_bubble",  0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0100, 0, 0, 0);
    cyc("misalign",    0,  0,  0,  1,  32'h42,       0,  32'h0,        0,   32'h0000_0104, 1, 0, 1);
    cyc("after_mis",   0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0108, 1, 0, 0);
    cyc("csr_mask_mis",0,  0,  0,  1,  32'h42,       1,  32'h1FF,      0,   32'h0000_010C, 1, 1, 0);
    cyc("csr_aligned", 0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_01FC, 0, 0, 0);
    cyc("br_bit0",     0,  1,  1,  0,  32'h301,      0,  32'h0,        0,   32'h0000_0200, 1, 1, 0);
    cyc("bubble_redir",0,  1,  1,  0,  32'h400,      0,  32'h0,        0,   32'h0000_0300, 0, 1, 0);
    cyc("bubble_again",0,  0,  0,  1,  32'h500,      0,  32'h0,        0,   32'h0000_0400, 0, 1, 0);

    // Assert reset mid-bubble, before the pending jump to 0x500 is taken.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst.pc", pc_o, 32'h0000_0000);

    cyc("rst_hold",    1,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0000, 1, 0, 0);
    cyc("rst_stall",   0,  0,  0,  0,  32'h0,        0,  32'h0,        1,   32'h0000_0000, 0, 0, 0);
    cyc("rst_fetch",   0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0000, 1, 0, 0);
    cyc("rst_next",    0,  0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0000_0004, 1, 0, 0);

`ifdef BRANCH_STATS_EN
    // Five counted branches (three taken) plus one stalled branch that is not counted.
    br_cyc(1, 1, 0);
    br_cyc(1, 0, 0);
    br_cyc(1, 1, 1);
    br_cyc(1, 1, 0);
    br_cyc(1, 0, 0);
    br_cyc(1, 1, 0);
    br_cyc(0, 0, 0);
    @(negedge clk);
    check("stats.total", br_total_o,     32'd5);
    check("stats.taken", br_taken_cnt_o, 32'd3);

    // Preload both counters to the top and confirm they saturate.
    force dut.u_branch_stats.total_q = 32'hFFFF_FFFF;
    force dut.u_branch_stats.taken_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_branch_stats.total_q;
    release dut.u_branch_stats.taken_q;
    br_cyc(1, 1, 0);
    br_cyc(1, 1, 0);
    br_cyc(0, 0, 0);
    @(negedge clk);
    check("stats.total_sat", br_total_o,     32'hFFFF_FFFF);
    check("stats.taken_sat", br_taken_cnt_o, 32'hFFFF_FFFF);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_redirect_ctrl
